mc_ctrl_fsm: RTL and testbench

- Multi-cycle control FSM for the MIPS CPU.
- Sequences the shared 32-bit ALU through the fetch, decode, execute, memory and writeback phases: one ALU is used for PC+4, the branch target and the execute step.
- Drives the ALU Func code, operand muxes, PC/IR/register-file/memory enables, branch resolution from the ALU sgn output, and overflow traps from the ALU err output.
- Sits between the instruction register (opcode/funct inputs) and the datapath muxes.

---
 rtl/mc_ctrl_fsm.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM sequencing a single shared ALU.
// Define MC_CTRL_TRAP_EN to enable overflow/illegal-instruction traps to vector 0x80.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_sgn,
    input  logic       alu_err,
    input  logic       mem_ready,
    output logic [5:0] alu_func,
    output logic [1:0] alu_srca,
    output logic [2:0] alu_srcb,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       exc,
    output logic [1:0] exc_cause,
    output logic       instr_done
);

    localparam logic [5:0] F_ADD = 6'b000010, F_SUB = 6'b000100, F_AND = 6'b001000;
    localparam logic [5:0] F_OR = 6'b010000, F_NOR = 6'b100000, F_SLTU = 6'b000101;
    localparam logic [5:0] F_SLT = 6'b001001, F_XOR = 6'b010001, F_PASSB = 6'b010010;
    localparam logic [5:0] F_SRA = 6'b011000, F_SRL = 6'b101000, F_SLL = 6'b110000;
    localparam logic [5:0] F_CMP_EQ = 6'b000110, F_CMP_NE = 6'b100001;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_ADDU = 6'b100001, FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011, FN_AND = 6'b100100, FN_OR = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110, FN_NOR = 6'b100111, FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [3:0] {
        S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3, S_EXEC_I = 4'd4,
        S_WB_R = 4'd5, S_WB_I = 4'd6, S_MEM_ADDR = 4'd7, S_MEM_RD = 4'd8, S_MEM_WB = 4'd9,
        S_MEM_WR = 4'd10, S_BRANCH = 4'd11, S_JUMP = 4'd12
`ifdef MC_CTRL_TRAP_EN
        , S_TRAP = 4'd13
`endif
    } state_t;

    state_t state_r;
    state_t next_state_s;

    // ALU code for an R-type funct; zero doubles as "not a recognised funct".
    function automatic logic [5:0] r_alu_func(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_ADDU: r_alu_func = F_ADD;
            FN_SUB, FN_SUBU: r_alu_func = F_SUB;
            FN_AND:          r_alu_func = F_AND;
            FN_OR:           r_alu_func = F_OR;
            FN_XOR:          r_alu_func = F_XOR;
            FN_NOR:          r_alu_func = F_NOR;
            FN_SLT:          r_alu_func = F_SLT;
            FN_SLTU:         r_alu_func = F_SLTU;
            FN_SLL:          r_alu_func = F_SLL;
            FN_SRL:          r_alu_func = F_SRL;
            FN_SRA:          r_alu_func = F_SRA;
            default:         r_alu_func = 6'd0;
        endcase
    endfunction

    function automatic logic r_legal(input logic [5:0] fn);
        r_legal = (r_alu_func(fn) != 6'd0);
    endfunction

    function automatic logic r_is_shift(input logic [5:0] fn);
        r_is_shift = (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

    function automatic logic [5:0] i_alu_func(input logic [5:0] op);
        case (op)
            OP_SLTI:  i_alu_func = F_SLT;
            OP_SLTIU: i_alu_func = F_SLTU;
            OP_ANDI:  i_alu_func = F_AND;
            OP_ORI:   i_alu_func = F_OR;
            OP_XORI:  i_alu_func = F_XOR;
            OP_LUI:   i_alu_func = F_PASSB;
            default:  i_alu_func = F_ADD;
        endcase
    endfunction

    // Logical immediates are zero-extended, lui shifts its immediate up by 16.
    function automatic logic [2:0] i_srcb(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: i_srcb = 3'd4;
            OP_LUI:                   i_srcb = 3'd5;
            default:                  i_srcb = 3'd2;
        endcase
    endfunction

`ifdef MC_CTRL_TRAP_EN
    localparam logic [1:0] CAUSE_OVF = 2'b01, CAUSE_ILL = 2'b10;
    logic [1:0] trap_cause_s;
`else
    logic unused_err_s;
    assign unused_err_s = alu_err;
`endif

    // State register; an asserted reset aborts any outstanding memory request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        next_state_s = state_r;
        alu_func   = 6'd0;
        alu_srca   = 2'd0;
        alu_srcb   = 3'd0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        wb_src     = 2'd0;
        exc        = 1'b0;
        instr_done = 1'b0;
`ifdef MC_CTRL_TRAP_EN
        trap_cause_s = 2'b00;
`endif
        case (state_r)
            S_RST: next_state_s = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                alu_srcb = 3'd1;
                alu_func = F_ADD;
                if (mem_ready) begin
                    pc_write     = 1'b1;
                    ir_write     = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_srcb = 3'd3;
                alu_func = F_ADD;
                case (opcode)
`ifdef MC_CTRL_TRAP_EN
                    OP_RTYPE: next_state_s = S_EXEC_R;
`else
                    OP_RTYPE: begin
                        if (r_legal(funct)) begin
                            next_state_s = S_EXEC_R;
                        end else begin
                            instr_done   = 1'b1;
                            next_state_s = S_FETCH;
                        end
                    end
`endif
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
                        next_state_s = S_EXEC_I;
                    OP_LW, OP_SW:   next_state_s = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
                    OP_J, OP_JAL:   next_state_s = S_JUMP;
`ifdef MC_CTRL_TRAP_EN
                    default: begin
                        trap_cause_s = CAUSE_ILL;
                        next_state_s = S_TRAP;
                    end
`else
                    default: begin
                        instr_done   = 1'b1;
                        next_state_s = S_FETCH;
                    end
`endif
                endcase
            end
            S_EXEC_R: begin
                alu_func = r_alu_func(funct);
                alu_srcb = 3'd0;
                if (r_is_shift(funct)) begin
                    alu_srca = 2'd2;
                end else begin
                    alu_srca = 2'd1;
                end
`ifdef MC_CTRL_TRAP_EN
                if (!r_legal(funct)) begin
                    trap_cause_s = CAUSE_ILL;
                    next_state_s = S_TRAP;
                end else if (alu_err && ((funct == FN_ADD) || (funct == FN_SUB))) begin
                    trap_cause_s = CAUSE_OVF;
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_WB_R;
                end
`else
                next_state_s = S_WB_R;
`endif
            end
            S_EXEC_I: begin
                alu_srca = 2'd1;
                alu_srcb = i_srcb(opcode);
                alu_func = i_alu_func(opcode);
`ifdef MC_CTRL_TRAP_EN
                if (alu_err && (opcode == OP_ADDI)) begin
                    trap_cause_s = CAUSE_OVF;
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_WB_I;
                end
`else
                next_state_s = S_WB_I;
`endif
            end
            S_WB_R, S_WB_I: begin
                reg_write    = 1'b1;
                reg_dst      = (state_r == S_WB_R) ? 2'd1 : 2'd0;
                instr_done   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_srca = 2'd1;
                alu_srcb = 3'd2;
                alu_func = F_ADD;
                if (opcode == OP_SW) begin
                    next_state_s = S_MEM_WR;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                wb_src       = 2'd1;
                instr_done   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_BRANCH: begin
                alu_srca     = 2'd1;
                alu_srcb     = 3'd0;
                alu_func     = (opcode == OP_BNE) ? F_CMP_NE : F_CMP_EQ;
                pc_write     = alu_sgn;
                pc_src       = 2'd1;
                instr_done   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                instr_done = 1'b1;
                // jal links the already-incremented PC before the PC reloads.
                if (opcode == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd2;
                    wb_src    = 2'd2;
                end else begin
                    reg_write = 1'b0;
                end
                next_state_s = S_FETCH;
            end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP: begin
                pc_write     = 1'b1;
                pc_src       = 2'd3;
                exc          = 1'b1;
                instr_done   = 1'b1;
                next_state_s = S_FETCH;
            end
`endif
            default: next_state_s = S_RST;
        endcase
    end

`ifdef MC_CTRL_TRAP_EN
    // Trap cause is captured on entry to TRAP so it is visible alongside exc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_cause <= 2'b00;
        end else if (next_state_s == S_TRAP) begin
            exc_cause <= trap_cause_s;
        end else begin
            exc_cause <= exc_cause;
        end
    end
`else
    assign exc_cause = 2'b00;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: instruction-level reference model, random and directed stimulus.
module tb_mc_ctrl_fsm;

    logic       clk, rst_n;
    logic [5:0] opcode, funct;
    logic       alu_sgn, alu_err, mem_ready;
    logic [5:0] alu_func;
    logic [1:0] alu_srca;
    logic [2:0] alu_srcb;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write, iord, mem_req, mem_we, reg_write;
    logic [1:0] reg_dst, wb_src;
    logic       exc;
    logic [1:0] exc_cause;
    logic       instr_done;

`ifdef MC_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_sgn(alu_sgn), .alu_err(alu_err), .mem_ready(mem_ready),
        .alu_func(alu_func), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write), .reg_dst(reg_dst),
        .wb_src(wb_src), .exc(exc), .exc_cause(exc_cause), .instr_done(instr_done)
    );

    logic [26:0] all_out;
    assign all_out = {alu_func, alu_srca, alu_srcb, pc_write, pc_src, ir_write, iord, mem_req,
                      mem_we, reg_write, reg_dst, wb_src, exc, exc_cause, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        int         nreq;
        int         nwe;
        int         nwr;
        logic [1:0] dst;
        logic [1:0] wbs;
        bit         chk_func;
        logic [5:0] func;
        logic [1:0] srca;
        logic [2:0] srcb;
        logic       pcw;
        bit         chk_pcsrc;
        logic [1:0] pcsrc;
        int         nexc;
        logic [1:0] cause;
    } exp_t;

    exp_t       sb_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cur_fw = 0;
    int         cur_mw = 0;
    logic [1:0] model_cause = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // R-type funct table: legality, ALU code, shift (shamt on A port), can overflow.
    task automatic r_info(input logic [5:0] fn, output bit lg, output logic [5:0] f,
                          output bit sh, output bit ov);
        lg = 1'b1; sh = 1'b0; ov = 1'b0; f = 6'd0;
        case (fn)
            6'h20: begin f = 6'b000010; ov = 1'b1; end
            6'h21: f = 6'b000010;
            6'h22: begin f = 6'b000100; ov = 1'b1; end
            6'h23: f = 6'b000100;
            6'h24: f = 6'b001000;
            6'h25: f = 6'b010000;
            6'h26: f = 6'b010001;
            6'h27: f = 6'b100000;
            6'h2a: f = 6'b001001;
            6'h2b: f = 6'b000101;
            6'h00: begin f = 6'b110000; sh = 1'b1; end
            6'h02: begin f = 6'b101000; sh = 1'b1; end
            6'h03: begin f = 6'b011000; sh = 1'b1; end
            default: lg = 1'b0;
        endcase
    endtask

    task automatic i_info(input logic [5:0] op, output bit lg, output logic [5:0] f,
                          output logic [2:0] sb);
        lg = 1'b1; f = 6'b000010; sb = 3'd2;
        case (op)
            6'h08, 6'h09: ;
            6'h0a: f = 6'b001001;
            6'h0b: f = 6'b000101;
            6'h0c: begin f = 6'b001000; sb = 3'd4; end
            6'h0d: begin f = 6'b010000; sb = 3'd4; end
            6'h0e: begin f = 6'b010001; sb = 3'd4; end
            6'h0f: begin f = 6'b010010; sb = 3'd5; end
            default: lg = 1'b0;
        endcase
    endtask

    // Instruction-level expectation from latencies and per-class control rules.
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic err,
                         input logic sgn, input int fw, input int mw, output exp_t e);
        bit lg, sh, ov, trap;
        logic [5:0] f;
        logic [2:0] sb;
        logic [1:0] tc;
        trap = 1'b0; tc = 2'b00;
        e.cycles = 0; e.nreq = 1 + fw; e.nwe = 0; e.nwr = 0; e.dst = 2'd0; e.wbs = 2'd0;
        e.chk_func = 1'b0; e.func = 6'd0; e.srca = 2'd0; e.srcb = 3'd0; e.pcw = 1'b0;
        e.chk_pcsrc = 1'b0; e.pcsrc = 2'd0; e.nexc = 0;
        i_info(op, lg, f, sb);
        if (op == 6'h00) begin
            r_info(fn, lg, f, sh, ov);
            if (!lg) begin
                e.cycles = TRAP_EN ? 4 : 2;
                trap = TRAP_EN; tc = 2'b10;
            end else begin
                e.cycles = 4; e.chk_func = 1'b1; e.func = f;
                e.srca = sh ? 2'd2 : 2'd1; e.srcb = 3'd0;
                if (TRAP_EN && ov && err) begin trap = 1'b1; tc = 2'b01; end
                else begin e.nwr = 1; e.dst = 2'd1; end
            end
        end else if (lg) begin
            e.cycles = 4; e.chk_func = 1'b1; e.func = f; e.srca = 2'd1; e.srcb = sb;
            if (TRAP_EN && op == 6'h08 && err) begin trap = 1'b1; tc = 2'b01; end
            else e.nwr = 1;
        end else begin
            case (op)
                6'h23: begin
                    e.cycles = 5 + mw; e.nreq = e.nreq + 1 + mw; e.nwr = 1; e.wbs = 2'd1;
                    e.chk_func = 1'b1; e.func = 6'b000010; e.srca = 2'd1; e.srcb = 3'd2;
                end
                6'h2b: begin
                    e.cycles = 4 + mw; e.nreq = e.nreq + 1 + mw; e.nwe = 1 + mw;
                    e.chk_func = 1'b1; e.func = 6'b000010; e.srca = 2'd1; e.srcb = 3'd2;
                end
                6'h04, 6'h05: begin
                    e.cycles = 3; e.chk_func = 1'b1; e.srca = 2'd1; e.srcb = 3'd0;
                    e.func = (op == 6'h05) ? 6'b100001 : 6'b000110;
                    e.pcw = sgn; e.chk_pcsrc = 1'b1; e.pcsrc = 2'd1;
                end
                6'h02, 6'h03: begin
                    e.cycles = 3; e.pcw = 1'b1; e.chk_pcsrc = 1'b1; e.pcsrc = 2'd2;
                    if (op == 6'h03) begin e.nwr = 1; e.dst = 2'd2; e.wbs = 2'd2; end
                end
                default: begin
                    e.cycles = TRAP_EN ? 3 : 2;
                    trap = TRAP_EN; tc = 2'b10;
                end
            endcase
        end
        if (trap) begin
            e.pcw = 1'b1; e.chk_pcsrc = 1'b1; e.pcsrc = 2'd3; e.nexc = 1;
            model_cause = tc;
        end
        e.cycles = e.cycles + fw;
        e.cause = model_cause;
    endtask

    // Driver: push expectation, apply instruction, wait (bounded) for completion.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic err,
                         input logic sgn, input int fw, input int mw);
        exp_t e;
        int n;
        bit done;
        model(op, fn, err, sgn, fw, mw, e);
        sb_q.push_back(e);
        opcode = op; funct = fn; alu_err = err; alu_sgn = sgn; cur_fw = fw; cur_mw = mw;
        n = 0; done = 1'b0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
            done = instr_done;
        end
        check("instr_done_seen", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Memory responder: completes each request after the configured number of wait cycles.
    initial begin
        int cnt;
        int need;
        cnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                need = iord ? cur_mw : cur_fw;
                if (cnt >= need) begin mem_ready = 1'b1; cnt = 0; end
                else begin mem_ready = 1'b0; cnt++; end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: accumulates per-instruction observations and compares on instr_done.
    initial begin
        exp_t e;
        bit started;
        int cyc, nreq, nwe, nwr, nexc, ir_age;
        logic [1:0] dst, wbs, srca;
        logic [5:0] func;
        logic [2:0] srcb;
        started = 1'b0; cyc = 0; nreq = 0; nwe = 0; nwr = 0; nexc = 0; ir_age = 7;
        dst = 2'd0; wbs = 2'd0; func = 6'd0; srca = 2'd0; srcb = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n || !started) begin
                cyc = 0; nreq = 0; nwe = 0; nwr = 0; nexc = 0; ir_age = 7;
                dst = 2'd0; wbs = 2'd0; func = 6'd0; srca = 2'd0; srcb = 3'd0;
                started = rst_n && mem_req;
            end
            if (started) begin
                cyc++;
                if (mem_req) nreq++;
                if (mem_we) nwe++;
                if (exc) nexc++;
                if (reg_write) begin nwr++; dst = reg_dst; wbs = wb_src; end
                if (ir_write) ir_age = 0;
                else if (ir_age != 7) ir_age++;
                if (ir_age == 2) begin func = alu_func; srca = alu_srca; srcb = alu_srcb; end
                if (instr_done) begin
                    started = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("unexpected_instr_done", 32'(instr_done), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("cycles", 32'(cyc), 32'(e.cycles));
                        check("mem_req_cycles", 32'(nreq), 32'(e.nreq));
                        check("mem_we_cycles", 32'(nwe), 32'(e.nwe));
                        check("reg_write_cycles", 32'(nwr), 32'(e.nwr));
                        if (e.nwr > 0) begin
                            check("reg_dst", 32'(dst), 32'(e.dst));
                            check("wb_src", 32'(wbs), 32'(e.wbs));
                        end
                        if (e.chk_func) begin
                            check("alu_func", 32'(func), 32'(e.func));
                            check("alu_srca", 32'(srca), 32'(e.srca));
                            check("alu_srcb", 32'(srcb), 32'(e.srcb));
                        end
                        check("pc_write_last", 32'(pc_write), 32'(e.pcw));
                        if (e.chk_pcsrc) check("pc_src_last", 32'(pc_src), 32'(e.pcsrc));
                        check("exc_cycles", 32'(nexc), 32'(e.nexc));
                        check("exc_cause", 32'(exc_cause), 32'(e.cause));
                    end
                end
            end
        end
    end

    logic [5:0] op_tab [20] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                                6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f,
                                6'h01, 6'h10};
    logic [5:0] fn_tab [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                                6'h2b, 6'h00, 6'h02, 6'h03, 6'h01, 6'h3f, 6'h08};

    initial begin
        int n;
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; alu_sgn = 1'b0; alu_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", 32'(all_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_cycle_outputs", 32'(all_out), 32'd0);

        issue(6'h00, 6'h20, 1'b0, 1'b0, 0, 0);   // add
        issue(6'h23, 6'h00, 1'b0, 1'b0, 0, 3);   // lw, 3 wait cycles
        issue(6'h04, 6'h00, 1'b0, 1'b1, 0, 0);   // beq taken
        issue(6'h04, 6'h00, 1'b0, 1'b0, 0, 0);   // beq not taken
        issue(6'h00, 6'h20, 1'b1, 1'b0, 0, 0);   // add overflow
        issue(6'h00, 6'h21, 1'b1, 1'b0, 0, 0);   // addu ignores overflow
        issue(6'h3f, 6'h00, 1'b0, 1'b0, 0, 0);   // illegal opcode
        issue(6'h00, 6'h00, 1'b0, 1'b0, 0, 0);   // sll
        issue(6'h08, 6'h00, 1'b1, 1'b0, 1, 0);   // addi overflow, fetch wait
        issue(6'h00, 6'h22, 1'b1, 1'b0, 0, 0);   // sub overflow
        issue(6'h00, 6'h3f, 1'b0, 1'b0, 0, 0);   // illegal funct
        issue(6'h03, 6'h00, 1'b0, 1'b0, 0, 0);   // jal
        issue(6'h2b, 6'h00, 1'b0, 1'b0, 2, 2);   // sw with waits
        issue(6'h0f, 6'h00, 1'b0, 1'b0, 0, 0);   // lui
        issue(6'h05, 6'h00, 1'b0, 1'b1, 0, 0);   // bne taken

        for (int k = 0; k < 80; k++) begin
            issue(op_tab[$urandom_range(0, 19)], fn_tab[$urandom_range(0, 15)],
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a stalled store.
        opcode = 6'h2b; funct = 6'h00; alu_err = 1'b0; cur_fw = 0; cur_mw = 1000;
        n = 0;
        while (!mem_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_mem_wr", 32'(mem_we), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        model_cause = 2'b00;
        #1;
        check("reset_abort_outputs", 32'(all_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("rst_after_abort_outputs", 32'(all_out), 32'd0);
        @(posedge clk);
        #1;
        check("fetch_after_rst", 32'({mem_req, iord, mem_we}), 32'b100);
        issue(6'h00, 6'h25, 1'b0, 1'b0, 0, 0);   // or after reset

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
